text_term_ctrl: RTL and testbench
=================================

Name: text_term_ctrl

Overview:
- Terminal-style write controller for the 70x30 text-mode VGA character memory (vmem).
- Accepts ASCII characters over a valid/ready stream, typically from the PS/2 keyboard decoder, and maintains a cursor.
- Issues single-port vmem writes in the display's column-major address format, `{col[6:0], row[4:0]}`.
- Handles newline, backspace, line wrap, row clearing on cursor entry, and full-screen clear. The VGA scan side only reads vmem and is not sequenced by this block.

Parameters:
- COLS, 70, character columns per row
- ROWS, 30, character rows per screen
- COL_W, 7, column index width
- ROW_W, 5, row index width
- BLANK, 8'h20, fill character used by clears and backspace

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  character available
- in_char  in  8  ASCII code
- in_ready  out  1  block can accept a character this cycle
- clr_req  in  1  request full-screen clear (level, sampled in IDLE)
- we  out  1  vmem write enable
- waddr  out  12  vmem address, `{col, row}`
- wdata  out  8  vmem write data
- cur_col  out  7  cursor column
- cur_row  out  5  cursor row
- busy  out  1  high in CLR_ROW or CLR_ALL

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high, and takes effect at any state, including mid-clear (the clear is abandoned).
- Reset values: state=IDLE, `we`=0, `waddr`=0, `wdata`=0, `cur_col`=0, `cur_row`=0, `busy`=0. No vmem writes are issued during reset.
- Registered outputs: `we`, `waddr`, `wdata`, `cur_col` and `cur_row` are registered. Any write caused by acceptance at cycle t appears at cycle t+1.
- in_ready: `in_ready = (state==IDLE) & ~clr_req & ~rst`. A character is accepted when `in_valid & in_ready`.
- FSM states: IDLE, CLR_ROW, CLR_ALL.
- IDLE, printable char (0x20..0x7E) accepted at cycle t:
  - t+1: `we`=1, `waddr={cur_col,cur_row}` (old cursor), `wdata`=char.
  - Cursor advances to col+1.
  - If the old col was COLS-1: col=0, row=row+1, and row ROWS-1 wraps to 0. Then enter CLR_ROW for the new row. `in_ready` stays low from t+1.
  - Otherwise remain in IDLE, so back-to-back accepts are allowed (1 char/cycle).
- IDLE, 0x0A or 0x0D accepted at cycle t:
  - No character write.
  - col=0, row=row+1 with wrap.
  - Enter CLR_ROW at t+1.
- IDLE, 0x08 (backspace):
  - If col>0: col=col-1, then write BLANK at the new cursor.
  - If col==0 and row>0: col=COLS-1, row=row-1, then write BLANK at the new cursor.
  - If at (0,0): consumed, no write, no cursor change.
  - The write appears at t+1.
- IDLE, any other code: consumed, no write, cursor unchanged.
- CLR_ROW (row R = new cursor row):
  - Issues COLS consecutive writes, `wdata`=BLANK, `waddr={k,R}` for k=0..COLS-1, one per cycle.
  - The first clear write is the cycle after the last IDLE-side write, or after acceptance for LF/CR.
  - Then return to IDLE. `busy`=1 throughout.
- CLR_ALL:
  - Entered from IDLE when `clr_req`=1; takes priority over a same-cycle `in_valid`, and that character is not accepted.
  - Issues ROWS*COLS = 2100 writes of BLANK, row-major: row 0..ROWS-1, col 0..COLS-1 within each row.
  - Addresses with row 30/31 are never written.
  - Cursor is set to (0,0) on entry.
  - Returns to IDLE after the last write.
  - `clr_req` in CLR_ROW/CLR_ALL is ignored (not queued).
- Write address rule: `waddr` is always `{col,row}`, never a col*ROWS+row product. Max address written is `{7'd69,5'd29}`.
- `we`=0 on every cycle without a write; `waddr`/`wdata` hold their last value.
- Cursor outputs reflect the post-update cursor from cycle t+1.

Test Plan:
- Reset, then send 'A' (0x41) at t → t+1: `we`=1, `waddr`=12'h000, `wdata`=0x41; `cur_col`=1, `cur_row`=0; `in_ready`=1 at t+1.
- Stream 70 printable chars back-to-back from (0,0) → 70 consecutive writes at `{0..69,0}`; then CLR_ROW writes BLANK at `{0..69,1}` over 70 cycles with `busy`=1, `in_ready`=0; then cursor (0,1) and IDLE.
- With cursor (5,29), send 0x0A → no char write; cursor (0,0); 70 BLANK writes to `{k,0}`; `in_ready` returns after 71 cycles.
- Backspace at (3,2) → write BLANK at `{2,2}`, cursor (2,2). Backspace at (0,2) → write at `{69,1}`, cursor (69,1). Backspace at (0,0) → no write, cursor unchanged.
- Assert `clr_req` together with `in_valid` (0x42) at cursor (10,7) → char not accepted; exactly 2100 writes of 0x20, first `{0,0}`, last `{69,29}`, none with row≥30; cursor (0,0).
- Assert `rst` mid-CLR_ALL after 500 writes → next cycle `we`=0, state IDLE, cursor (0,0), `busy`=0.

Source files
------------

// File: rtl/text_term_if.sv
`default_nettype none
// ============================================================================
// Module   : text_term_if
// Purpose  : Character stream, clear request and vmem write bundle for the
//            text terminal write controller.
// Revision : 1.0
// ============================================================================
interface text_term_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 5
);
    logic                     in_valid;
    logic [7:0]               in_char;
    logic                     in_ready;
    logic                     clr_req;
    logic                     we;
    logic [COL_W+ROW_W-1:0]   waddr;
    logic [7:0]               wdata;
    logic [COL_W-1:0]         cur_col;
    logic [ROW_W-1:0]         cur_row;
    logic                     busy;

    modport master (
        output in_valid, in_char, clr_req,
        input  in_ready, we, waddr, wdata, cur_col, cur_row, busy
    );

    modport slave (
        input  in_valid, in_char, clr_req,
        output in_ready, we, waddr, wdata, cur_col, cur_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/text_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_term_ctrl
// Purpose  : Terminal-style cursor and write sequencer for the 70x30
//            column-major text-mode character memory.
// Revision : 1.0
// ============================================================================
module text_term_ctrl #(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter int         COL_W = 7,
    parameter int         ROW_W = 5,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    text_term_if.slave  term
);

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR_ROW = 2'd1,
        S_CLR_ALL = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_we, w_we_nxt;
    logic [COL_W+ROW_W-1:0]   r_waddr, w_waddr_nxt;
    logic [7:0]               r_wdata, w_wdata_nxt;
    logic [COL_W-1:0]         r_col, w_col_nxt;
    logic [ROW_W-1:0]         r_row, w_row_nxt;
    logic [COL_W-1:0]         r_clr_col, w_clr_col_nxt;
    logic [ROW_W-1:0]         r_clr_row, w_clr_row_nxt;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_printable;
    logic [ROW_W-1:0]         w_row_inc;

    assign w_in_ready  = (r_state == S_IDLE) & ~term.clr_req & ~rst;
    assign w_accept    = term.in_valid & w_in_ready;
    assign w_printable = (term.in_char >= 8'h20) && (term.in_char <= 8'h7E);
    assign w_row_inc   = (r_row == c_LAST_ROW) ? '0 : r_row + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_clr_col <= '0;
            r_clr_row <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_clr_col <= w_clr_col_nxt;
            r_clr_row <= w_clr_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_we_nxt      = 1'b0;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_clr_col_nxt = r_clr_col;
        w_clr_row_nxt = r_clr_row;

        case (r_state)
            S_IDLE: begin
                // A clear request wins over a character presented in the same cycle.
                if (term.clr_req) begin
                    w_state_nxt   = S_CLR_ALL;
                    w_col_nxt     = '0;
                    w_row_nxt     = '0;
                    w_clr_col_nxt = '0;
                    w_clr_row_nxt = '0;
                end else if (w_accept) begin
                    if (w_printable) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = {r_col, r_row};
                        w_wdata_nxt = term.in_char;
                        if (r_col == c_LAST_COL) begin
                            w_col_nxt     = '0;
                            w_row_nxt     = w_row_inc;
                            w_clr_col_nxt = '0;
                            w_state_nxt   = S_CLR_ROW;
                        end else begin
                            w_col_nxt = r_col + COL_W'(1);
                        end
                    end else if (term.in_char == 8'h0A || term.in_char == 8'h0D) begin
                        w_col_nxt     = '0;
                        w_row_nxt     = w_row_inc;
                        w_clr_col_nxt = '0;
                        w_state_nxt   = S_CLR_ROW;
                    end else if (term.in_char == 8'h08) begin
                        if (r_col != '0) begin
                            w_col_nxt   = r_col - COL_W'(1);
                            w_we_nxt    = 1'b1;
                            w_waddr_nxt = {w_col_nxt, r_row};
                            w_wdata_nxt = BLANK;
                        end else if (r_row != '0) begin
                            w_col_nxt   = c_LAST_COL;
                            w_row_nxt   = r_row - ROW_W'(1);
                            w_we_nxt    = 1'b1;
                            w_waddr_nxt = {c_LAST_COL, w_row_nxt};
                            w_wdata_nxt = BLANK;
                        end
                    end
                end
            end

            S_CLR_ROW: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = {r_clr_col, r_row};
                w_wdata_nxt = BLANK;
                if (r_clr_col == c_LAST_COL) begin
                    w_clr_col_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_clr_col_nxt = r_clr_col + COL_W'(1);
                end
            end

            S_CLR_ALL: begin
                // Row-major sweep; rows past ROWS-1 are never visited.
                w_we_nxt    = 1'b1;
                w_waddr_nxt = {r_clr_col, r_clr_row};
                w_wdata_nxt = BLANK;
                if (r_clr_col == c_LAST_COL) begin
                    w_clr_col_nxt = '0;
                    if (r_clr_row == c_LAST_ROW) begin
                        w_clr_row_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_clr_row_nxt = r_clr_row + ROW_W'(1);
                    end
                end else begin
                    w_clr_col_nxt = r_clr_col + COL_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign term.in_ready = w_in_ready;
    assign term.we       = r_we;
    assign term.waddr    = r_waddr;
    assign term.wdata    = r_wdata;
    assign term.cur_col  = r_col;
    assign term.cur_row  = r_row;
    assign term.busy     = (r_state == S_CLR_ROW) || (r_state == S_CLR_ALL);

endmodule
`default_nettype wire

// File: tb/tb_text_term_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_term_ctrl
// Purpose  : Self-checking bench for text_term_ctrl against a cursor/screen
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_text_term_ctrl;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;

    text_term_if tif ();

    text_term_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .term (tif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: cursor and the ordered list of expected writes.
    int          m_col;
    int          m_row;
    logic [19:0] exp_q[$];
    logic [19:0] act_q[$];

    always @(negedge clk) begin
        if (tif.we === 1'b1) act_q.push_back({tif.waddr, tif.wdata});
    end

    function automatic logic [19:0] wr(int c, int r, logic [7:0] d);
        return {7'(c), 5'(r), d};
    endfunction

    function automatic void model_new_line();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int k = 0; k < COLS; k++) exp_q.push_back(wr(k, m_row, 8'h20));
    endfunction

    function automatic void model_apply(logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back(wr(m_col, m_row, c));
            if (m_col == COLS - 1) model_new_line();
            else m_col++;
        end else if (c == 8'h0A || c == 8'h0D) begin
            model_new_line();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back(wr(m_col, m_row, 8'h20));
            end else if (m_row > 0) begin
                m_col = COLS - 1;
                m_row--;
                exp_q.push_back(wr(m_col, m_row, 8'h20));
            end
        end
    endfunction

    function automatic void model_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_q.push_back(wr(c, r, 8'h20));
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tif.in_valid = 1'b0;
        tif.clr_req  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        m_col = 0;
        m_row = 0;
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (tif.in_ready !== 1'b1 && k < 5000) begin
            tick();
            k++;
        end
        if (tif.in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", tif.in_ready, k);
        end
    endtask

    task automatic put(logic [7:0] c);
        wait_ready();
        tif.in_valid = 1'b1;
        tif.in_char  = c;
        tick();
        tif.in_valid = 1'b0;
        model_apply(c);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({tif.we, tif.waddr, tif.wdata} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_write_port: got we=%b waddr=%h wdata=%h, required all zero",
                     tif.we, tif.waddr, tif.wdata);
        end
        n_tests++;
        if (tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)", tif.cur_col, tif.cur_row);
        end
        n_tests++;
        if (tif.busy !== 1'b0 || tif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b in_ready=%b, required busy=0 in_ready=1",
                     tif.busy, tif.in_ready);
        end
    endtask

    task automatic test_first_char();
        do_reset();
        tif.in_valid = 1'b1;
        tif.in_char  = 8'h41;
        tick();
        tif.in_valid = 1'b0;
        n_tests++;
        if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, 12'h000, 8'h41}) begin
            n_fail++;
            $display("FAIL first_char_write: got we=%b waddr=%h wdata=%h, required we=1 waddr=000 wdata=41",
                     tif.we, tif.waddr, tif.wdata);
        end
        n_tests++;
        if (tif.cur_col !== 7'd1 || tif.cur_row !== 5'd0 || tif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_char_cursor: got (%0d,%0d) in_ready=%b, required (1,0) in_ready=1",
                     tif.cur_col, tif.cur_row, tif.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c;
        int         bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < COLS; i++) begin
            c = rand_print();
            tif.in_valid = 1'b1;
            tif.in_char  = c;
            tick();
            n_tests++;
            if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, wr(i, 0, c)}) begin
                n_fail++;
                $display("FAIL stream_write[%0d]: got we=%b addr=%h data=%h, required we=1 addr/data=%h",
                         i, tif.we, tif.waddr, tif.wdata, wr(i, 0, c));
            end
        end
        tif.in_valid = 1'b0;
        n_tests++;
        if (tif.in_ready !== 1'b0 || tif.busy !== 1'b1 || tif.cur_col !== 7'd0 || tif.cur_row !== 5'd1) begin
            n_fail++;
            $display("FAIL stream_wrap: got in_ready=%b busy=%b cursor (%0d,%0d), required 0,1,(0,1)",
                     tif.in_ready, tif.busy, tif.cur_col, tif.cur_row);
        end
        for (int k = 0; k < COLS; k++) begin
            tick();
            if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, wr(k, 1, 8'h20)}) bad++;
            if (tif.in_ready !== (k == COLS - 1)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_row_clear: got %0d bad cycles, required 0", bad);
        end
        n_tests++;
        if (tif.cur_col !== 7'd0 || tif.cur_row !== 5'd1 || tif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got cursor (%0d,%0d) busy=%b, required (0,1) busy=0",
                     tif.cur_col, tif.cur_row, tif.busy);
        end
    endtask

    task automatic test_newline_wrap();
        int bad;
        do_reset();
        repeat (ROWS - 1) put(8'h0A);
        repeat (5) put(rand_print());
        wait_ready();
        n_tests++;
        if (tif.cur_col !== 7'(m_col) || tif.cur_row !== 5'(m_row) || m_col != 5 || m_row != 29) begin
            n_fail++;
            $display("FAIL nl_setup: got (%0d,%0d), required (5,29)", tif.cur_col, tif.cur_row);
        end
        tif.in_valid = 1'b1;
        tif.in_char  = 8'h0A;
        tick();
        tif.in_valid = 1'b0;
        n_tests++;
        if (tif.we !== 1'b0 || tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0 || tif.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL nl_accept: got we=%b cursor (%0d,%0d) in_ready=%b, required 0,(0,0),0",
                     tif.we, tif.cur_col, tif.cur_row, tif.in_ready);
        end
        bad = 0;
        for (int k = 0; k < COLS; k++) begin
            tick();
            if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, wr(k, 0, 8'h20)}) bad++;
            if (tif.in_ready !== (k == COLS - 1)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nl_row_clear: got %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        put(8'h0A);
        put(8'h0A);
        repeat (3) put(rand_print());
        wait_ready();
        put(8'h08);
        n_tests++;
        if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, wr(2, 2, 8'h20)} || tif.cur_col !== 7'd2 || tif.cur_row !== 5'd2) begin
            n_fail++;
            $display("FAIL bs_mid_row: got we=%b addr=%h data=%h cursor (%0d,%0d), required addr/data=%h cursor (2,2)",
                     tif.we, tif.waddr, tif.wdata, tif.cur_col, tif.cur_row, wr(2, 2, 8'h20));
        end
        put(8'h08);
        put(8'h08);
        put(8'h08);
        n_tests++;
        if ({tif.we, tif.waddr, tif.wdata} !== {1'b1, wr(69, 1, 8'h20)} || tif.cur_col !== 7'd69 || tif.cur_row !== 5'd1) begin
            n_fail++;
            $display("FAIL bs_row_start: got we=%b addr=%h data=%h cursor (%0d,%0d), required addr/data=%h cursor (69,1)",
                     tif.we, tif.waddr, tif.wdata, tif.cur_col, tif.cur_row, wr(69, 1, 8'h20));
        end
        do_reset();
        put(8'h08);
        n_tests++;
        if (tif.we !== 1'b0 || tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0 || tif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bs_origin: got we=%b cursor (%0d,%0d) in_ready=%b, required 0,(0,0),1",
                     tif.we, tif.cur_col, tif.cur_row, tif.in_ready);
        end
    endtask

    task automatic test_clear_all();
        int          n, bad, row_bad;
        logic [19:0] first_w, last_w;
        do_reset();
        repeat (7) put(8'h0A);
        repeat (10) put(rand_print());
        wait_ready();
        tif.clr_req  = 1'b1;
        tif.in_valid = 1'b1;
        tif.in_char  = 8'h42;
        tick();
        tif.clr_req  = 1'b0;
        tif.in_valid = 1'b0;
        n_tests++;
        if (tif.we !== 1'b0 || tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0 || tif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_entry: got we=%b cursor (%0d,%0d) busy=%b, required 0,(0,0),1",
                     tif.we, tif.cur_col, tif.cur_row, tif.busy);
        end
        n = 0; bad = 0; row_bad = 0;
        first_w = '0; last_w = '0;
        for (int cyc = 0; cyc < ROWS * COLS + 10; cyc++) begin
            tick();
            if (tif.we === 1'b1) begin
                if (n == 0) first_w = {tif.waddr, tif.wdata};
                last_w = {tif.waddr, tif.wdata};
                if ({tif.waddr, tif.wdata} !== wr(n % COLS, n / COLS, 8'h20)) bad++;
                if (tif.waddr[4:0] >= 5'd30) row_bad++;
                n++;
            end
        end
        n_tests++;
        if (n != ROWS * COLS) begin
            n_fail++;
            $display("FAIL clr_count: got %0d writes, required %0d", n, ROWS * COLS);
        end
        n_tests++;
        if (bad != 0 || row_bad != 0) begin
            n_fail++;
            $display("FAIL clr_sequence: got %0d out-of-order and %0d row>=30 writes, required 0", bad, row_bad);
        end
        n_tests++;
        if (first_w !== wr(0, 0, 8'h20) || last_w !== wr(69, 29, 8'h20)) begin
            n_fail++;
            $display("FAIL clr_ends: got first %h last %h, required first %h last %h",
                     first_w, last_w, wr(0, 0, 8'h20), wr(69, 29, 8'h20));
        end
        n_tests++;
        if (tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0 || tif.in_ready !== 1'b1 || tif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_exit: got cursor (%0d,%0d) in_ready=%b busy=%b, required (0,0),1,0",
                     tif.cur_col, tif.cur_row, tif.in_ready, tif.busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n, cyc;
        do_reset();
        put(rand_print());
        wait_ready();
        tif.clr_req = 1'b1;
        tick();
        tif.clr_req = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 500 && cyc < 700) begin
            tick();
            if (tif.we === 1'b1) n++;
            cyc++;
        end
        n_tests++;
        if (n != 500) begin
            n_fail++;
            $display("FAIL midclr_progress: got %0d writes in %0d cycles, required 500", n, cyc);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (tif.we !== 1'b0 || tif.busy !== 1'b0 || tif.cur_col !== 7'd0 || tif.cur_row !== 5'd0) begin
            n_fail++;
            $display("FAIL midclr_reset: got we=%b busy=%b cursor (%0d,%0d), required 0,0,(0,0)",
                     tif.we, tif.busy, tif.cur_col, tif.cur_row);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (tif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midclr_idle: got in_ready=%b, required 1", tif.in_ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        int         r, nacc, nclr, cyc, bad_idx;
        logic       v, acc;
        do_reset();
        nacc = 0; nclr = 0; cyc = 0;
        while (nacc < 400 && cyc < 40000) begin
            if (tif.busy === 1'b0 && nclr < 2 && $urandom_range(0, 199) == 0) begin
                tif.clr_req  = 1'b1;
                tif.in_valid = 1'($urandom_range(0, 1));
                tif.in_char  = rand_print();
                tick();
                tif.clr_req  = 1'b0;
                model_clear_all();
                nclr++;
            end else begin
                r = $urandom_range(0, 19);
                if (r < 2)       c = (r == 0) ? 8'h0A : 8'h0D;
                else if (r < 4)  c = 8'h08;
                else if (r == 4) c = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 7));
                else             c = rand_print();
                v = ($urandom_range(0, 3) != 0);
                tif.in_valid = v;
                tif.in_char  = c;
                #1;
                acc = v && (tif.in_ready === 1'b1);
                tick();
                if (acc) begin
                    model_apply(c);
                    nacc++;
                end
            end
            cyc++;
        end
        tif.in_valid = 1'b0;
        wait_ready();
        tick();
        tick();
        bad_idx = -1;
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            if (exp_q[i] !== act_q[i] && bad_idx < 0) bad_idx = i;
        n_tests++;
        if (exp_q.size() != act_q.size() || bad_idx >= 0) begin
            n_fail++;
            $display("FAIL random_writes: got %0d writes (first diff idx %0d act %h), required %0d writes (exp %h)",
                     act_q.size(), bad_idx, (bad_idx >= 0) ? act_q[bad_idx] : 20'h0,
                     exp_q.size(), (bad_idx >= 0) ? exp_q[bad_idx] : 20'h0);
        end
        n_tests++;
        if (tif.cur_col !== 7'(m_col) || tif.cur_row !== 5'(m_row)) begin
            n_fail++;
            $display("FAIL random_cursor: got (%0d,%0d), required (%0d,%0d)",
                     tif.cur_col, tif.cur_row, m_col, m_row);
        end
    endtask

    initial begin
        tif.in_valid = 1'b0;
        tif.in_char  = 8'h00;
        tif.clr_req  = 1'b0;
        test_reset();
        test_first_char();
        test_back_to_back();
        test_newline_wrap();
        test_backspace();
        test_clear_all();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
